// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit ALU, one operation in flight at a time.
// Latency: grant edge, one EXEC edge writes the result register, HOLD until the consumer takes it.
// Backpressure: readies are low outside IDLE, so a stalled consumer holds off both requesters.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       req1_ready,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_id,
    input  logic       res_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;       // 1: requester 1 wins a tie
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] sel_q, sel_d;
    logic       id_q, id_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_id_q, res_id_d;

    logic       grant0;
    logic       grant1;
    logic [7:0] a_ext;
    logic [7:0] b_ext;
    logic [7:0] alu_res;

    // Grant is gated by rst_n so no ready can leak out while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (req0_valid && (!req1_valid || !ptr_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign a_ext = {4'b0000, a_q};
    assign b_ext = {4'b0000, b_q};

    always_comb begin
        alu_res = 8'h00;
        case (sel_q)
            3'b000:  alu_res = a_ext + b_ext;
            3'b001:  alu_res = a_ext - b_ext;
            3'b010:  alu_res = a_ext & b_ext;
            3'b011:  alu_res = a_ext | b_ext;
            3'b100:  alu_res = a_ext ^ b_ext;
            3'b101:  alu_res = ~a_ext;
            3'b110:  alu_res = a_ext * b_ext;
            default: alu_res = a_ext << b_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    sel_d   = req0_sel;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = ST_EXEC;
                end else if (grant1) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    sel_d   = req1_sel;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d  = alu_res;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            a_q         <= 4'h0;
            b_q         <= 4'h0;
            sel_q       <= 3'b000;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = 4'h0, req0_b = 4'h0, req1_a = 4'h0, req1_b = 4'h0;
    logic [2:0] req0_sel = 3'b0, req1_sel = 3'b0;
    logic       req0_ready, req1_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ready = 1'b0;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 computing, 2 waiting for the consumer.
    int m_phase, m_pref, m_a, m_b, m_sel, m_id, m_rv, m_rd, m_rid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int alu_ref(input int a, input int b, input int sel);
        int r;
        case (sel)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = a * b;
            default: r = (b >= 8) ? 0 : a * (1 << b);
        endcase
        return r & 255;
    endfunction

    function automatic int winner();
        if (!rst_n || m_phase != 0) return -1;
        if (req0_valid && req1_valid) return m_pref;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pref = 0; m_a = 0; m_b = 0; m_sel = 0; m_id = 0;
        m_rv = 0; m_rd = 0; m_rid = 0;
    endtask

    task automatic model_step();
        int w;
        if (!rst_n) return;
        case (m_phase)
            0: begin
                w = winner();
                if (w == 0) begin
                    m_a = req0_a; m_b = req0_b; m_sel = req0_sel;
                end else if (w == 1) begin
                    m_a = req1_a; m_b = req1_b; m_sel = req1_sel;
                end
                if (w >= 0) begin
                    m_id = w; m_pref = 1 - w; m_phase = 1;
                end
            end
            1: begin
                m_rd = alu_ref(m_a, m_b, m_sel); m_rid = m_id; m_rv = 1; m_phase = 2;
            end
            default: begin
                if (res_ready) begin
                    m_rv = 0; m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string where);
        int w;
        w = winner();
        chk({where, ".ready0"}, req0_ready, (w == 0));
        chk({where, ".ready1"}, req1_ready, (w == 1));
        chk({where, ".res_valid"}, res_valid, m_rv);
        chk({where, ".res_data"}, res_data, m_rd);
        chk({where, ".res_id"}, res_id, m_rid);
        chk({where, ".busy"}, busy, (m_phase != 0));
    endtask

    // Inputs are driven at posedge+1; outputs compared at negedge; model advances on posedge.
    task automatic tick(input string where);
        @(negedge clk);
        check_outputs(where);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        if (idx == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
        end
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("drain");
    endtask

    initial begin
        int want_id, nres;
        logic [7:0] sweep [8];
        sweep[0] = 8'h0D; sweep[1] = 8'h07; sweep[2] = 8'h02; sweep[3] = 8'h0B;
        sweep[4] = 8'h09; sweep[5] = 8'hF5; sweep[6] = 8'h1E; sweep[7] = 8'h50;

        // Reset, with a valid already presented to prove ready is held low.
        model_reset();
        req0_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_outputs("reset");
        chk("reset.ready0_low", req0_ready, 0);
        tick("reset"); tick("reset");
        rst_n = 1'b1;
        req0_valid = 1'b0;
        res_ready = 1'b1;

        // Single subtract: 3-5 wraps to 0xFE, id 0.
        set_req(0, 1'b1, 4'd3, 4'd5, 3'b001);
        #1 chk("single.first_grant", req0_ready, 1);
        tick("single");
        req0_valid = 1'b0;
        chk("single.e0_rv", res_valid, 0);
        tick("single");
        chk("single.e1_rv", res_valid, 1);
        chk("single.data", res_data, 8'hFE);
        chk("single.id", res_id, 0);
        drain();

        // Opcode sweep with a=0xA, b=0x3.
        for (int s = 0; s < 8; s++) begin
            set_req(0, 1'b1, 4'hA, 4'h3, s[2:0]);
            tick("sweep");
            req0_valid = 1'b0;
            tick("sweep");
            chk($sformatf("sweep.op%0d", s), res_data, sweep[s]);
            tick("sweep");
        end
        drain();

        // Contention right after reset: grants alternate starting with requester 0.
        rst_n = 1'b0; model_reset();
        tick("cont_rst");
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'd15, 4'd15, 3'b110);
        set_req(1, 1'b1, 4'd1, 4'd9, 3'b111);
        res_ready = 1'b1;
        want_id = 0; nres = 0;
        for (int i = 0; i < 12; i++) begin
            tick("cont");
            if (res_valid) begin
                chk("cont.id_alt", res_id, want_id);
                chk("cont.data", res_data, (want_id == 0) ? 8'hE1 : 8'h00);
                want_id = 1 - want_id;
                nres++;
            end
        end
        chk("cont.throughput", nres, 4);
        drain();

        // Backpressure: consumer stalls 5 cycles while requester 1 keeps valid high.
        set_req(1, 1'b1, 4'd2, 4'd3, 3'b000);
        res_ready = 1'b0;
        tick("bp"); tick("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp.data", res_data, 8'h05);
            chk("bp.id", res_id, 1);
            chk("bp.ready1", req1_ready, 0);
            chk("bp.busy", busy, 1);
            tick("bp");
        end
        res_ready = 1'b1;
        tick("bp_rel");
        chk("bp.rel_busy", busy, 0);
        chk("bp.rel_rv", res_valid, 0);
        chk("bp.rel_regrant", req1_ready, 1);
        req1_valid = 1'b0;
        drain();

        // Reset during EXEC discards the operation.
        set_req(0, 1'b1, 4'd7, 4'd1, 3'b000);
        tick("rmid");
        chk("rmid.in_exec", busy, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rmid.rv_low", res_valid, 0);
        chk("rmid.busy_low", busy, 0);
        chk("rmid.ready_low", req0_ready, 0);
        tick("rmid"); tick("rmid");
        rst_n = 1'b1;
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick("rmid_rel");
        chk("rmid.no_result", res_valid, 0);
        set_req(0, 1'b1, 4'd1, 4'd1, 3'b000);
        set_req(1, 1'b1, 4'd1, 4'd1, 3'b000);
        #1 chk("rmid.grant0", req0_ready, 1);
        chk("rmid.grant1_low", req1_ready, 0);
        tick("rmid_cont");
        drain();

        // Idle cancel: a valid pulse that never sees an edge.
        set_req(1, 1'b1, 4'd4, 4'd4, 3'b010);
        #2 req1_valid = 1'b0;
        tick("cancel");
        chk("cancel.busy", busy, 0);
        tick("cancel");
        chk("cancel.rv", res_valid, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
